multi_cycle_ctrl: RTL and testbench

- Parametrised control unit for the multi-cycle CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB and emits the datapath write enables.
- Adds what the current fixed controller lacks: a req/ack memory handshake with variable latency, a configurable timeout into a sticky error state, a HALT state, and a retired-instruction counter.
- Sits between the instruction register (opcode source) and the PC, IR, register file and memory.

---
 rtl/cpu_ctrl_pkg.sv | 26 ++
 rtl/multi_cycle_ctrl_if.sv | 32 +++
 rtl/wait_timer.sv | 36 +++
 rtl/multi_cycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM state codes and
// the opcode values the controller decodes.
package cpu_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int OPC_W   = 6;

    typedef enum logic [STATE_W-1:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
    localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: opcode and memory handshake in,
// state, write enables and status out.
interface multi_cycle_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
);
    logic [OP_W-1:0]    op;
    logic               memAck;
    logic [STATE_W-1:0] State;
    logic               IRWre;
    logic               PCWre;
    logic               RegWre;
    logic               memReq;
    logic               memWr;
    logic               halted;
    logic               error;
    logic [CNT_W-1:0]   instrCount;

    // Controller side
    modport master (
        input  op, memAck,
        output State, IRWre, PCWre, RegWre, memReq, memWr, halted, error, instrCount
    );

    // Datapath / memory side
    modport slave (
        output op, memAck,
        input  State, IRWre, PCWre, RegWre, memReq, memWr, halted, error, instrCount
    );
endinterface

// File: rtl/wait_timer.sv
// Counts consecutive cycles spent waiting on memAck within one state and flags
// the cycle at which the wait budget runs out.
module wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int WAIT_W  = 8
) (
    input  logic clk,
    input  logic Reset,
    input  logic waiting,
    input  logic stateChange,
    output logic expire
);
    logic [WAIT_W-1:0] waitCnt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            waitCnt <= '0;
        end else if (stateChange) begin
            waitCnt <= '0;
        end else if (waiting && (waitCnt != {WAIT_W{1'b1}})) begin
            waitCnt <= waitCnt + WAIT_W'(1);
        end
    end

    // TIMEOUT==0 means wait forever; the counter still runs but never fires.
    generate
        if (TIMEOUT == 0) begin : gNoTimeout
            logic unusedCnt;
            assign unusedCnt = ^waitCnt;
            assign expire    = 1'b0 & unusedCnt;
        end else begin : gTimeout
            assign expire = waiting && (waitCnt == WAIT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: sequences IF/ID/EXE/MEM/WB with a variable
// latency memory handshake, timeout into ERR, HALT, and a retired counter.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 16,
    parameter int WAIT_W  = 8,
    parameter int CNT_W   = 32
) (
    input logic                clk,
    input logic                Reset,
    multi_cycle_ctrl_if.master bus
);

    state_t           state;
    state_t           nextState;
    logic [OP_W-1:0]  opReg;
    logic [CNT_W-1:0] instrCount;

    logic irWre;
    logic pcWre;
    logic regWre;
    logic memReq;
    logic memWr;
    logic waiting;
    logic stateChange;
    logic expire;

    function automatic logic isOp(input logic [OP_W-1:0] a, input logic [OPC_W-1:0] code);
        return a == OP_W'(code);
    endfunction

    function automatic logic isExec(input logic [OP_W-1:0] a);
        return isOp(a, OP_R) || isOp(a, OP_ADDI) || isOp(a, OP_LW) ||
               isOp(a, OP_SW) || isOp(a, OP_BEQ);
    endfunction

    assign waiting     = ((state == S_IF) || (state == S_MEM)) && !bus.memAck;
    assign stateChange = (nextState != state);

    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .WAIT_W  (WAIT_W)
    ) uTimer (
        .clk         (clk),
        .Reset       (Reset),
        .waiting     (waiting),
        .stateChange (stateChange),
        .expire      (expire)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= S_IF;
            opReg      <= '0;
            instrCount <= '0;
        end else begin
            state <= nextState;
            if (state == S_ID) begin
                opReg <= bus.op;
            end
            if (pcWre) begin
                instrCount <= instrCount + CNT_W'(1);
            end
        end
    end

    // The live opcode is only consulted in ID; later phases rely on opReg.
    always_comb begin
        nextState = state;
        irWre     = 1'b0;
        pcWre     = 1'b0;
        regWre    = 1'b0;
        memReq    = 1'b0;
        memWr     = 1'b0;
        case (state)
            S_IF: begin
                memReq = 1'b1;
                if (bus.memAck) begin
                    irWre     = 1'b1;
                    nextState = S_ID;
                end else if (expire) begin
                    nextState = S_ERR;
                end
            end
            S_ID: begin
                if (isOp(bus.op, OP_J)) begin
                    pcWre     = 1'b1;
                    nextState = S_IF;
                end else if (isOp(bus.op, OP_HALT)) begin
                    nextState = S_HALT;
                end else if (isExec(bus.op)) begin
                    nextState = S_EXE;
                end else begin
                    nextState = S_ERR;
                end
            end
            S_EXE: begin
                if (isOp(opReg, OP_BEQ)) begin
                    pcWre     = 1'b1;
                    nextState = S_IF;
                end else if (isOp(opReg, OP_LW) || isOp(opReg, OP_SW)) begin
                    nextState = S_MEM;
                end else begin
                    nextState = S_WB;
                end
            end
            S_MEM: begin
                memReq = 1'b1;
                memWr  = isOp(opReg, OP_SW);
                if (bus.memAck) begin
                    if (isOp(opReg, OP_SW)) begin
                        pcWre     = 1'b1;
                        nextState = S_IF;
                    end else begin
                        nextState = S_WB;
                    end
                end else if (expire) begin
                    nextState = S_ERR;
                end
            end
            S_WB: begin
                regWre    = 1'b1;
                pcWre     = 1'b1;
                nextState = S_IF;
            end
            S_HALT, S_ERR: begin
                nextState = state;
            end
            default: begin
                nextState = S_ERR;
            end
        endcase
    end

    assign bus.State      = state;
    assign bus.IRWre      = irWre;
    assign bus.PCWre      = pcWre;
    assign bus.RegWre     = regWre;
    assign bus.memReq     = memReq;
    assign bus.memWr      = memWr;
    assign bus.halted     = (state == S_HALT);
    assign bus.error      = (state == S_ERR);
    assign bus.instrCount = instrCount;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: instruction-level expected traces built from
// opcode class and memory wait counts, replayed cycle by cycle.
module tb_multi_cycle_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic        ack;
        logic [9:0]  exp;
        logic [31:0] cnt;
    } cyc_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    int          nErr = 0;
    int          nChecks = 0;
    logic [31:0] expCnt = '0;
    cyc_t        tr[$];

    multi_cycle_ctrl_if #(.OP_W(6), .CNT_W(32)) bus();

    multi_cycle_ctrl #(
        .OP_W(6), .TIMEOUT(TO), .WAIT_W(8), .CNT_W(32)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // {State, IRWre, PCWre, RegWre, memReq, memWr, halted, error}
    function automatic logic [9:0] ev(input int st, input logic irw, input logic pcw,
                                      input logic regw, input logic mreq, input logic mwr);
        logic [2:0] s;
        s = st[2:0];
        return {s, irw, pcw, regw, mreq, mwr, (st == 5), (st == 6)};
    endfunction

    function automatic void push(input logic [5:0] o, input logic a, input logic [9:0] e);
        cyc_t c;
        c.rst = 1'b0; c.op = o; c.ack = a; c.exp = e; c.cnt = expCnt;
        tr.push_back(c);
    endfunction

    function automatic void pushRst(input logic [9:0] e);
        cyc_t c;
        c.rst = 1'b1; c.op = rnd6(); c.ack = rb(); c.exp = e; c.cnt = expCnt;
        tr.push_back(c);
        expCnt = '0;
    endfunction

    function automatic logic retires(input logic [5:0] o);
        return (o == OP_R) || (o == OP_ADDI) || (o == OP_LW) || (o == OP_SW) ||
               (o == OP_BEQ) || (o == OP_J);
    endfunction

    // Expected cycles of one instruction: w1 IF waits, w2 MEM waits (< TO)
    function automatic void buildInstr(input logic [5:0] o, input int w1, input int w2);
        logic isSw;
        isSw = (o == OP_SW);
        for (int i = 0; i < w1; i++) push(rnd6(), 1'b0, ev(0, 0, 0, 0, 1, 0));
        push(rnd6(), 1'b1, ev(0, 1, 0, 0, 1, 0));
        push(o, rb(), ev(1, 0, (o == OP_J), 0, 0, 0));
        if (o == OP_BEQ) begin
            push(rnd6(), rb(), ev(2, 0, 1, 0, 0, 0));
        end else if ((o == OP_R) || (o == OP_ADDI)) begin
            push(rnd6(), rb(), ev(2, 0, 0, 0, 0, 0));
            push(rnd6(), rb(), ev(4, 0, 1, 1, 0, 0));
        end else if ((o == OP_LW) || isSw) begin
            push(rnd6(), rb(), ev(2, 0, 0, 0, 0, 0));
            for (int i = 0; i < w2; i++) push(rnd6(), 1'b0, ev(3, 0, 0, 0, 1, isSw));
            push(rnd6(), 1'b1, ev(3, 0, isSw, 0, 1, isSw));
            if (!isSw) push(rnd6(), rb(), ev(4, 0, 1, 1, 0, 0));
        end
        if (retires(o)) expCnt = expCnt + 32'd1;
    endfunction

    function automatic void pushIdle();
        push(rnd6(), 1'b0, ev(0, 0, 0, 0, 1, 0));
    endfunction

    task automatic driveCycle(input cyc_t c, output logic [9:0] obs, output logic [31:0] cnt);
        Reset = c.rst;
        bus.op = c.op;
        bus.memAck = c.ack;
        #1;
        obs = {bus.State, bus.IRWre, bus.PCWre, bus.RegWre, bus.memReq, bus.memWr,
               bus.halted, bus.error};
        cnt = bus.instrCount;
        @(negedge clk);
    endtask

    task automatic doReset();
        Reset = 1'b1;
        bus.memAck = 1'b0;
        bus.op = '0;
        tr.delete();
        @(negedge clk);
        Reset = 1'b0;
        expCnt = '0;
    endtask

    task automatic test_reset();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        doReset();
        pushIdle();
        push(rnd6(), 1'b1, ev(0, 1, 0, 0, 1, 0));
        push(OP_R, rb(), ev(1, 0, 0, 0, 0, 0));
        pushRst(ev(2, 0, 0, 0, 0, 0));
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL reset cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL reset cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    task automatic test_rtype();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        doReset();
        buildInstr(OP_R, 0, 0);
        buildInstr(OP_ADDI, 0, 0);
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL rtype cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL rtype cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    task automatic test_lw_wait();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        doReset();
        buildInstr(OP_LW, 0, 3);
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL lw_wait cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL lw_wait cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    task automatic test_sw();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        doReset();
        buildInstr(OP_SW, 0, 0);
        buildInstr(OP_SW, 2, 1);
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL sw cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL sw cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        logic [5:0] legal [6];
        legal[0] = OP_R; legal[1] = OP_ADDI; legal[2] = OP_LW;
        legal[3] = OP_SW; legal[4] = OP_BEQ; legal[5] = OP_J;
        doReset();
        for (int i = 0; i < 40; i++) begin
            buildInstr(legal[$urandom_range(0, 5)], $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL b2b cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL b2b cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    task automatic test_halt();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        doReset();
        buildInstr(OP_J, 1, 0);
        buildInstr(OP_BEQ, 0, 0);
        buildInstr(OP_HALT, 0, 0);
        for (int i = 0; i < 3; i++) push(rnd6(), rb(), ev(5, 0, 0, 0, 0, 0));
        pushRst(ev(5, 0, 0, 0, 0, 0));
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL halt cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL halt cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    task automatic test_timeout();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        logic isSw;
        doReset();
        // IF starved of memAck
        for (int i = 0; i < TO; i++) push(rnd6(), 1'b0, ev(0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) push(rnd6(), rb(), ev(6, 0, 0, 0, 0, 0));
        pushRst(ev(6, 0, 0, 0, 0, 0));
        // MEM starved of memAck after one retired instruction
        buildInstr(OP_R, 0, 0);
        isSw = rb();
        push(rnd6(), 1'b1, ev(0, 1, 0, 0, 1, 0));
        push(isSw ? OP_SW : OP_LW, rb(), ev(1, 0, 0, 0, 0, 0));
        push(rnd6(), rb(), ev(2, 0, 0, 0, 0, 0));
        for (int i = 0; i < TO; i++) push(rnd6(), 1'b0, ev(3, 0, 0, 0, 1, isSw));
        for (int i = 0; i < 2; i++) push(rnd6(), rb(), ev(6, 0, 0, 0, 0, 0));
        pushRst(ev(6, 0, 0, 0, 0, 0));
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL timeout cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL timeout cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    task automatic test_illegal();
        logic [9:0] obs; logic [31:0] cnt; cyc_t c; int k = 0;
        logic [5:0] bad;
        doReset();
        buildInstr(6'b110011, TO - 1, 0);
        for (int i = 0; i < 2; i++) push(rnd6(), rb(), ev(6, 0, 0, 0, 0, 0));
        pushRst(ev(6, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            do bad = rnd6(); while (retires(bad) || (bad == OP_HALT));
            buildInstr(bad, $urandom_range(0, TO - 1), 0);
            push(rnd6(), rb(), ev(6, 0, 0, 0, 0, 0));
            pushRst(ev(6, 0, 0, 0, 0, 0));
        end
        pushIdle();
        while (tr.size() > 0) begin
            c = tr.pop_front();
            driveCycle(c, obs, cnt);
            nChecks += 2;
            if (obs !== c.exp) begin nErr++; $display("FAIL illegal cyc%0d outputs: got %b want %b", k, obs, c.exp); end
            if (cnt !== c.cnt) begin nErr++; $display("FAIL illegal cyc%0d instrCount: got %0d want %0d", k, cnt, c.cnt); end
            k++;
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.memAck = 1'b0;
        bus.op = '0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
